// File: rtl/unsigned_calc_seq_v.sv
// unsigned_calc_seq_v
// Computes F = 7X - 3Y + 6Z for three 4-bit unsigned operands. A single
// shared 9-bit signed add/subtract unit and a 9-bit accumulator are used,
// and each product is built from shifted operands. The result is either
// wrapped to 8 bits or saturated to +127, depending on SAT_EN.
//
// Sequence after a start is accepted in IDLE:
//   A8 (+X<<3) -> A1 (-X) -> B2 (-Y<<1) -> B1 (-Y) -> C4 (+Z<<2)
//   -> C2 (+Z<<1) -> DONE -> IDLE
// o_busy is high for the seven cycles A8..DONE. o_done is high only in DONE,
// which is the first cycle in which the registered result is valid.
// Consecutive starts are therefore spaced eight cycles apart.

module unsigned_calc_seq_v #(
  parameter bit SAT_EN = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [3:0]        i_au,
  input  logic [3:0]        i_bu,
  input  logic [3:0]        i_cu,
  output logic              o_busy,
  output logic              o_done,
  output logic signed [7:0] o_fu,
  output logic              o_ovf
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] A8   = 3'd1;
  localparam logic [2:0] A1   = 3'd2;
  localparam logic [2:0] B2   = 3'd3;
  localparam logic [2:0] B1   = 3'd4;
  localparam logic [2:0] C4   = 3'd5;
  localparam logic [2:0] C2   = 3'd6;
  localparam logic [2:0] DONE = 3'd7;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [3:0]        x_reg;
  logic [3:0]        y_reg;
  logic [3:0]        z_reg;
  logic signed [8:0] acc;
  logic signed [8:0] operand;
  logic              subtract;
  logic signed [8:0] alu_out;
  logic              final_ovf;
  logic [7:0]        final_fu;

  // Choose the shifted operand and the add/subtract direction for the current step
  always_comb begin
    operand  = 9'sd0;
    subtract = 1'b0;
    case (state)
      A8: begin
        operand  = $signed({2'b00, x_reg, 3'b000});
        subtract = 1'b0;
      end
      A1: begin
        operand  = $signed({5'b00000, x_reg});
        subtract = 1'b1;
      end
      B2: begin
        operand  = $signed({4'b0000, y_reg, 1'b0});
        subtract = 1'b1;
      end
      B1: begin
        operand  = $signed({5'b00000, y_reg});
        subtract = 1'b1;
      end
      C4: begin
        operand  = $signed({3'b000, z_reg, 2'b00});
        subtract = 1'b0;
      end
      C2: begin
        operand  = $signed({4'b0000, z_reg, 1'b0});
        subtract = 1'b0;
      end
      default: begin
        operand  = 9'sd0;
        subtract = 1'b0;
      end
    endcase
  end

  // Shared adder/subtractor; intermediate values stay within -45..+195, so 9 bits never wrap
  always_comb begin
    alu_out = subtract ? (acc - operand) : (acc + operand);
  end

  // Result formatting for the final step: positive overflow flag plus wrap or saturate
  always_comb begin
    final_ovf = (alu_out > 9'sd127);
    if (SAT_EN && final_ovf) begin
      final_fu = 8'h7F;
    end else begin
      final_fu = alu_out[7:0];
    end
  end

  // Next-state sequencing; i_start is only looked at in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = i_start ? A8 : IDLE;
      A8:      state_next = A1;
      A1:      state_next = B2;
      B2:      state_next = B1;
      B1:      state_next = C4;
      C4:      state_next = C2;
      C2:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture and accumulator update; operands are frozen once a start is accepted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_reg <= 4'd0;
      y_reg <= 4'd0;
      z_reg <= 4'd0;
      acc   <= 9'sd0;
    end else if (state == IDLE) begin
      if (i_start) begin
        x_reg <= i_au;
        y_reg <= i_bu;
        z_reg <= i_cu;
        acc   <= 9'sd0;
      end
    end else if (state != DONE) begin
      acc <= alu_out;
    end
  end

  // Result registers only load on the C2 to DONE transition and hold otherwise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fu  <= 8'sh00;
      o_ovf <= 1'b0;
    end else if (state == C2) begin
      o_fu  <= $signed(final_fu);
      o_ovf <= final_ovf;
    end
  end

  assign o_busy = (state != IDLE);
  assign o_done = (state == DONE);

endmodule

// File: tb/tb_unsigned_calc_seq_v.sv
// tb_unsigned_calc_seq_v
// Directed bench for unsigned_calc_seq_v. It drives a wrapping instance
// (SAT_EN=0) and a saturating instance (SAT_EN=1) from the same inputs.
// Expected results are hand-computed from F = 7X - 3Y + 6Z.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.

module tb_unsigned_calc_seq_v;

  logic              clk;
  logic              rst;
  logic              start;
  logic [3:0]        au;
  logic [3:0]        bu;
  logic [3:0]        cu;
  logic              busy;
  logic              done;
  logic signed [7:0] fu;
  logic              ovf;
  logic              busy_s;
  logic              done_s;
  logic signed [7:0] fu_s;
  logic              ovf_s;

  int checks = 0;
  int errors = 0;

  logic [7:0] prev_fu;
  logic [7:0] prev_fu_s;
  logic       prev_ovf;

  unsigned_calc_seq_v #(.SAT_EN(1'b0)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_au    (au),
    .i_bu    (bu),
    .i_cu    (cu),
    .o_busy  (busy),
    .o_done  (done),
    .o_fu    (fu),
    .o_ovf   (ovf)
  );

  unsigned_calc_seq_v #(.SAT_EN(1'b1)) dut_sat (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_au    (au),
    .i_bu    (bu),
    .i_cu    (cu),
    .o_busy  (busy_s),
    .o_done  (done_s),
    .o_fu    (fu_s),
    .o_ovf   (ovf_s)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge while the DUT is in IDLE; acceptance happens on the next rising edge.
  // With hold=0, start is dropped and the operands are scrambled afterwards.
  // With hold=1, start stays high and the next operand set (nx/ny/nz) is applied.
  task automatic apply_stimulus(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z,
                                input bit hold, input logic [3:0] nx, input logic [3:0] ny,
                                input logic [3:0] nz);
    au    = x;
    bu    = y;
    cu    = z;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hold) begin
      au = nx;
      bu = ny;
      cu = nz;
    end else begin
      start = 1'b0;
      au    = ~x;
      bu    = ~y;
      cu    = ~z;
    end
  endtask

  // Follows the eight cycles after acceptance: seven busy cycles with done in the
  // seventh, then one idle cycle. The results must hold until done.
  task automatic expect_run(input string tag, input logic [7:0] exp_fu, input logic exp_ovf,
                            input logic [7:0] exp_fu_s);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check_output({tag, "_busy"}, busy, 1'b1);
      check_output({tag, "_done"}, done, (c == 7) ? 1'b1 : 1'b0);
      if (c < 7) begin
        check_output({tag, "_hold_fu"}, fu, prev_fu);
        check_output({tag, "_hold_ovf"}, ovf, prev_ovf);
        check_output({tag, "_hold_fu_sat"}, fu_s, prev_fu_s);
      end else begin
        check_output({tag, "_fu"}, fu, exp_fu);
        check_output({tag, "_ovf"}, ovf, exp_ovf);
        check_output({tag, "_fu_sat"}, fu_s, exp_fu_s);
        check_output({tag, "_ovf_sat"}, ovf_s, exp_ovf);
        check_output({tag, "_done_sat"}, done_s, 1'b1);
      end
    end
    @(negedge clk);
    check_output({tag, "_idle_busy"}, busy, 1'b0);
    check_output({tag, "_idle_done"}, done, 1'b0);
    prev_fu   = exp_fu;
    prev_fu_s = exp_fu_s;
    prev_ovf  = exp_ovf;
  endtask

  // Directed sequence
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    au        = 4'd0;
    bu        = 4'd0;
    cu        = 4'd0;
    prev_fu   = 8'h00;
    prev_fu_s = 8'h00;
    prev_ovf  = 1'b0;
    #1;
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_done", done, 1'b0);
    check_output("reset_fu", fu, 8'h00);
    check_output("reset_ovf", ovf, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic: 7 - 6 + 18 = 19
    apply_stimulus(4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 4'd0, 4'd0);
    expect_run("basic", 8'h13, 1'b0, 8'h13);
    // Most negative: -45
    apply_stimulus(4'd0, 4'd15, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    expect_run("neg45", 8'hD3, 1'b0, 8'hD3);
    // Maximum result: 195
    apply_stimulus(4'd15, 4'd0, 4'd15, 1'b0, 4'd0, 4'd0, 4'd0);
    expect_run("max195", 8'hC3, 1'b1, 8'h7F);
    // All fifteen: 150
    apply_stimulus(4'd15, 4'd15, 4'd15, 1'b0, 4'd0, 4'd0, 4'd0);
    expect_run("all15", 8'h96, 1'b1, 8'h7F);
    // Boundary values: 127, 128 and -1
    apply_stimulus(4'd13, 4'd0, 4'd6, 1'b0, 4'd0, 4'd0, 4'd0);
    expect_run("edge127", 8'h7F, 1'b0, 8'h7F);
    apply_stimulus(4'd14, 4'd0, 4'd5, 1'b0, 4'd0, 4'd0, 4'd0);
    expect_run("edge128", 8'h80, 1'b1, 8'h7F);
    apply_stimulus(4'd2, 4'd15, 4'd5, 1'b0, 4'd0, 4'd0, 4'd0);
    expect_run("minus1", 8'hFF, 1'b0, 8'hFF);

    // Start held high, with operands changed mid-run: 19, then -45, then 195
    apply_stimulus(4'd1, 4'd2, 4'd3, 1'b1, 4'd0, 4'd15, 4'd0);
    expect_run("cont1", 8'h13, 1'b0, 8'h13);
    apply_stimulus(4'd0, 4'd15, 4'd0, 1'b1, 4'd15, 4'd0, 4'd15);
    expect_run("cont2", 8'hD3, 1'b0, 8'hD3);
    apply_stimulus(4'd15, 4'd0, 4'd15, 1'b0, 4'd0, 4'd0, 4'd0);
    expect_run("cont3", 8'hC3, 1'b1, 8'h7F);

    // Reset during B2 (third cycle after acceptance) aborts the run with no done pulse
    apply_stimulus(4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_output("b2_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_done", done, 1'b0);
    check_output("rst_fu", fu, 8'h00);
    check_output("rst_ovf", ovf, 1'b0);
    check_output("rst_fu_sat", fu_s, 8'h00);
    check_output("rst_ovf_sat", ovf_s, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    prev_fu   = 8'h00;
    prev_fu_s = 8'h00;
    prev_ovf  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_output("abort_done", done, 1'b0);
      check_output("abort_busy", busy, 1'b0);
    end
    apply_stimulus(4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    expect_run("zero", 8'h00, 1'b0, 8'h00);

    // Start coincident with the first rising edge after reset release
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(4'd9, 4'd0, 4'd11, 1'b0, 4'd0, 4'd0, 4'd0);
    expect_run("post_rst", 8'h81, 1'b1, 8'h7F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
